x9_fetch_unit: RTL and testbench
================================

Name: x9_fetch_unit

Overview:
- Instruction-fetch stage of the X9 core: program counter, branch target lookup table and fetch register.
- Drives the address of the instruction ROM (ir1) and registers the 9-bit word returned.
- Hands the registered instruction to decode/control, which feeds rf1/dm1.
- Detects the halt instruction and raises the top-level done flag that benches wait on.

Parameters:
- PC_W, 10: program counter / ROM address width.
- INSTR_W, 9: instruction width.
- LUT_DEPTH, 32: branch target table entries; index width is $clog2(LUT_DEPTH).
- HALT_INSTR, 9'h1FF: encoding that terminates the program.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- instr_addr  out  PC_W  current PC, to the instruction ROM (combinational read).
- instr_in  in  INSTR_W  ROM data at instr_addr, same cycle.
- instr_out  out  INSTR_W  registered fetched instruction.
- instr_valid  out  1  instr_out is a live, non-squashed instruction.
- stall  in  1  hold the whole stage.
- branch_taken  in  1  control resolved a taken branch for the instruction in instr_out.
- branch_idx  in  $clog2(LUT_DEPTH)  LUT index of the branch target.
- lut_we  in  1  LUT write strobe (preload).
- lut_waddr  in  $clog2(LUT_DEPTH)  LUT write index.
- lut_wdata  in  PC_W  LUT write data (absolute target).
- done  out  1  program halted; sticky until reset.

Behaviour:
- Reset (reset==0 at posedge):
  - pc=0, instr_out=0, instr_valid=0, done=0, state=IDLE.
  - LUT contents are retained, so a preload survives reset.
- States: IDLE, RUN, HALT.
- IDLE: first cycle after reset release. pc holds 0 and instr_valid=0; go to RUN unconditionally.
- RUN, stall==0, per posedge:
  - instr_out <= instr_in.
  - instr_valid <= 1, unless squashed or halt (below).
  - pc <= branch_taken ? lut[branch_idx] : pc+1.
- Taken branch (branch_taken==1 && instr_valid==1):
  - The word fetched this cycle is wrong-path: instr_valid <= 0 and pc <= target.
  - Penalty is 1 bubble; the target instruction is valid the following cycle.
  - branch_taken while instr_valid==0 is ignored.
- Stall: stall==1 holds pc, instr_out, instr_valid and state. Stall has priority over branch_taken; control keeps branch_taken asserted until stall drops.
- Halt:
  - Triggered when instr_in==HALT_INSTR is fetched in RUN, not stalled and not squashed.
  - Then: instr_valid <= 0 (halt is never issued), done <= 1 on that posedge, state <= HALT, pc frozen.
  - A halt fetched in the same cycle as a taken branch is wrong-path and ignored.
- HALT: everything frozen, instr_valid=0, done=1; only reset leaves HALT.
- PC wrap: pc+1 is modulo 2^PC_W, so 1023 goes to 0 with no flag.
- LUT: synchronous write on posedge when lut_we==1, in any state including reset. Reads are combinational; a same-cycle write/read of one index returns the old value.
- All outputs are registered except instr_addr, which is the pc register itself.

Optional Feature:
- Macro: X9_FETCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count [15:0].
  - Cleared by reset.
  - Increments every RUN cycle, stalls included, and saturates at 16'hFFFF.
  - Frozen in IDLE/HALT.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package x9_pkg:
  - INSTR_W and PC_W defaults.
  - HALT_INSTR.
  - typedef enum fetch_state_t {IDLE, RUN, HALT}.
- Sub-module x9_branch_lut: LUT_DEPTH x PC_W register array with one sync write port and one comb read port. The fetch unit instantiates it once.

Test Plan:
1. Sequence ROM[0..3]=9'h001..004, ROM[4]=9'h1FF; release reset.
   - instr_addr goes 0,0(IDLE),1,2,3,4.
   - instr_out 001..004 with valid=1.
   - done=1 the posedge addr 4 is fetched; instr_addr stays 4 thereafter.
2. Taken branch: preload lut[3]=40; assert branch_taken, idx=3 while instr_out=ROM[5].
   - Next instr_addr=40; one cycle valid=0; then instr_out=ROM[40], valid=1.
3. Stall: stall=1 for 3 cycles at instr_addr=7 → instr_addr, instr_out and instr_valid unchanged for 3 cycles; resumes at 8.
4. Wrap: lut[0]=1023, branch taken → addr 1023, then addr 0 with valid=1.
5. Reset mid-run: reset=0 at instr_addr=20 → next cycle addr 0, valid=0, done=0; the previously written lut[3]=40 is still readable.
6. Branch squashes halt: ROM[9]=9'h1FF, branch taken while addr 9 is fetched → done stays 0 and pc goes to the target. With X9_FETCH_CYCLE_COUNT_EN, also check that cycle_count counts RUN cycles only.

Source files
------------

// File: rtl/x9_pkg.sv
// Shared definitions for the X9 fetch stage: default widths, the halt
// encoding and the fetch FSM state type.
package x9_pkg;

    localparam int unsigned PC_W_DEF      = 10;
    localparam int unsigned INSTR_W_DEF   = 9;
    localparam int unsigned LUT_DEPTH_DEF = 32;

    localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/x9_branch_lut.sv
// Branch target lookup table: LUT_DEPTH x PC_W registers, one synchronous
// write port and one combinational read port. Contents have no reset so a
// preload survives a core reset; a same-cycle write/read returns the old value.
module x9_branch_lut
    import x9_pkg::*;
#(
    parameter int unsigned LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int unsigned PC_W      = PC_W_DEF
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(LUT_DEPTH)-1:0] waddr,
    input  logic [PC_W-1:0]              wdata,
    input  logic [$clog2(LUT_DEPTH)-1:0] raddr,
    output logic [PC_W-1:0]              rdata
);

    logic [PC_W-1:0] mem [LUT_DEPTH];

    // Preload write port, active in every core state including reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/x9_fetch_unit.sv
// X9 instruction-fetch stage: program counter, branch target LUT and fetch
// register, with halt detection driving the sticky done flag.
// Optional feature macro: X9_FETCH_CYCLE_COUNT_EN adds a saturating 16-bit
// count of RUN cycles on output cycle_count.
module x9_fetch_unit
    import x9_pkg::*;
#(
    parameter int unsigned        PC_W       = PC_W_DEF,
    parameter int unsigned        INSTR_W    = INSTR_W_DEF,
    parameter int unsigned        LUT_DEPTH  = LUT_DEPTH_DEF,
    parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_INSTR_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [PC_W-1:0]              instr_addr,
    input  logic [INSTR_W-1:0]           instr_in,
    output logic [INSTR_W-1:0]           instr_out,
    output logic                         instr_valid,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [$clog2(LUT_DEPTH)-1:0] branch_idx,
    input  logic                         lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
    input  logic [PC_W-1:0]              lut_wdata,
    output logic                         done
`ifdef X9_FETCH_CYCLE_COUNT_EN
    ,
    output logic [15:0]                  cycle_count
`endif
);

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      pc_next;
    logic [PC_W-1:0]      lut_target;
    logic [INSTR_W-1:0]   instr_next;
    logic                 valid_next;
    logic                 done_next;
    logic                 squash;
    logic                 halt_hit;

    x9_branch_lut #(
        .LUT_DEPTH (LUT_DEPTH),
        .PC_W      (PC_W)
    ) u_lut (
        .clk   (clk),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (branch_idx),
        .rdata (lut_target)
    );

    assign instr_addr = pc;

    // A taken branch only counts against a live instruction; the word fetched
    // alongside it is wrong-path, so a halt in that slot is ignored.
    assign squash   = branch_taken && instr_valid;
    assign halt_hit = (instr_in == HALT_INSTR) && !squash;

    // Next-state and next-output decode; stall holds everything in RUN.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr_out;
        valid_next = instr_valid;
        done_next  = done;
        case (state)
            IDLE: begin
                state_next = RUN;
                valid_next = 1'b0;
            end
            RUN: begin
                if (!stall) begin
                    instr_next = instr_in;
                    if (squash) begin
                        valid_next = 1'b0;
                        pc_next    = lut_target;
                    end else if (halt_hit) begin
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = HALT;
                    end else begin
                        valid_next = 1'b1;
                        pc_next    = pc + PC_W'(1);
                    end
                end
            end
            HALT: begin
                valid_next = 1'b0;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_out   <= instr_next;
            instr_valid <= valid_next;
            done        <= done_next;
        end
    end

`ifdef X9_FETCH_CYCLE_COUNT_EN
    // Saturating count of RUN cycles, stalled cycles included.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (state == RUN && cycle_count != '1) begin
            cycle_count <= cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_x9_fetch_unit.sv
// Directed self-checking bench for x9_fetch_unit with a behavioural ROM.
module tb_x9_fetch_unit;

    logic        clk;
    logic        reset;
    logic [9:0]  instr_addr;
    logic [8:0]  instr_in;
    logic [8:0]  instr_out;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [4:0]  branch_idx;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic        done;
`ifdef X9_FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    logic [8:0]  rom [1024];

    int checks;
    int failures;

    x9_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .instr_addr   (instr_addr),
        .instr_in     (instr_in),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_idx   (branch_idx),
        .lut_we       (lut_we),
        .lut_waddr    (lut_waddr),
        .lut_wdata    (lut_wdata),
        .done         (done)
`ifdef X9_FETCH_CYCLE_COUNT_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    assign instr_in = rom[instr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lut_write(input logic [4:0] idx, input logic [9:0] data);
        lut_we    = 1'b1;
        lut_waddr = idx;
        lut_wdata = data;
        tick(1);
        lut_we    = 1'b0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i + 32);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_idx   = '0;
        lut_we       = 1'b0;
        lut_waddr    = '0;
        lut_wdata    = '0;
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h004;
        rom[4] = 9'h1FF;
        #1;

        // Preload under reset
        lut_write(5'd3, 10'd40);
        lut_write(5'd0, 10'd1023);
        check("rst_addr",  instr_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_out",   instr_out, 0);
        check("rst_done",  done, 0);

        // Test 1: sequential fetch then halt
        reset = 1'b1;
        tick(1);
        check("t1_idle_addr",  instr_addr, 0);
        check("t1_idle_valid", instr_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t1_seq_addr",  instr_addr, k + 1);
            check("t1_seq_out",   instr_out, k + 1);
            check("t1_seq_valid", instr_valid, 1);
            check("t1_seq_done",  done, 0);
        end
        tick(1);
        check("t1_halt_done",  done, 1);
        check("t1_halt_valid", instr_valid, 0);
        check("t1_halt_addr",  instr_addr, 4);
`ifdef X9_FETCH_CYCLE_COUNT_EN
        check("t1_cc_halt", cycle_count, 5);
`endif
        tick(2);
        check("t1_frozen_addr", instr_addr, 4);
        check("t1_frozen_done", done, 1);
        check("t1_frozen_valid", instr_valid, 0);
`ifdef X9_FETCH_CYCLE_COUNT_EN
        check("t1_cc_frozen", cycle_count, 5);
`endif

        // Test 2: taken branch, bubble, branch ignored on bubble, stall priority
        fill_rom();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(7);
        check("t2_pre_out",  instr_out, 9'h025);
        check("t2_pre_addr", instr_addr, 6);
        branch_taken = 1'b1;
        branch_idx   = 5'd3;
        tick(1);
        check("t2_tgt_addr",    instr_addr, 40);
        check("t2_bubble_valid", instr_valid, 0);
        tick(1);
        check("t2_ign_addr",  instr_addr, 41);
        check("t2_tgt_out",   instr_out, 9'h048);
        check("t2_tgt_valid", instr_valid, 1);
        stall = 1'b1;
        tick(1);
        check("t2_stallbr_addr",  instr_addr, 41);
        check("t2_stallbr_valid", instr_valid, 1);
        stall = 1'b0;
        tick(1);
        check("t2_afterstall_addr",  instr_addr, 40);
        check("t2_afterstall_valid", instr_valid, 0);
        branch_taken = 1'b0;
        tick(1);
        check("t2_resume_out", instr_out, 9'h048);

        // Test 3: stall at addr 7, then reset mid-run at addr 20
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(8);
        check("t3_pre_addr", instr_addr, 7);
        check("t3_pre_out",  instr_out, 9'h026);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("t3_stall_addr",  instr_addr, 7);
            check("t3_stall_out",   instr_out, 9'h026);
            check("t3_stall_valid", instr_valid, 1);
        end
        stall = 1'b0;
        tick(1);
        check("t3_resume_addr", instr_addr, 8);
        check("t3_resume_out",  instr_out, 9'h027);
        tick(12);
        check("t5_pre_addr", instr_addr, 20);
        reset = 1'b0;
        tick(1);
        check("t5_rst_addr",  instr_addr, 0);
        check("t5_rst_valid", instr_valid, 0);
        check("t5_rst_done",  done, 0);
`ifdef X9_FETCH_CYCLE_COUNT_EN
        check("t5_rst_cc", cycle_count, 0);
`endif
        reset = 1'b1;
        tick(3);
        check("t5_run_out", instr_out, 9'h021);
        branch_taken = 1'b1;
        branch_idx   = 5'd3;
        tick(1);
        check("t5_lut_kept_addr", instr_addr, 40);
        branch_taken = 1'b0;
        tick(1);

        // Test 4: branch to 1023 and wrap to 0
        check("t4_pre_valid", instr_valid, 1);
        branch_taken = 1'b1;
        branch_idx   = 5'd0;
        tick(1);
        check("t4_wrap_addr", instr_addr, 1023);
        branch_taken = 1'b0;
        tick(1);
        check("t4_wrap0_addr",  instr_addr, 0);
        check("t4_wrap0_valid", instr_valid, 1);
        check("t4_wrap0_out",   instr_out, 9'h01F);
        tick(1);
        check("t4_wrap1_addr", instr_addr, 1);

        // Test 6: branch squashes a halt, then a real halt
        rom[9]  = 9'h1FF;
        rom[42] = 9'h1FF;
        tick(8);
        check("t6_pre_addr",  instr_addr, 9);
        check("t6_pre_valid", instr_valid, 1);
        branch_taken = 1'b1;
        branch_idx   = 5'd3;
        tick(1);
        check("t6_sq_done", done, 0);
        check("t6_sq_addr", instr_addr, 40);
        branch_taken = 1'b0;
        tick(2);
        check("t6_run_addr", instr_addr, 42);
        check("t6_run_out",  instr_out, 9'h049);
        tick(1);
        check("t6_halt_done", done, 1);
        check("t6_halt_addr", instr_addr, 42);
        branch_taken = 1'b1;
        branch_idx   = 5'd0;
        tick(1);
        check("t6_frozen_addr",  instr_addr, 42);
        check("t6_frozen_valid", instr_valid, 0);
        check("t6_frozen_done",  done, 1);
        branch_taken = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
